// File: rtl/aes_pkg.sv
// Shared AES constants: forward S-box, round constants and key-schedule state encoding.
package aes_pkg;

    localparam int unsigned NUM_ROUNDS = 10;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } ks_state_e;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
        8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
        8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
        8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
        8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
        8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
        8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
        8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
        8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
        8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
        8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
        8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
        8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
        8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Indexed by the round being produced (1..10); the padding keeps any 4-bit index in range.
    localparam logic [7:0] RCON [16] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

endpackage

// File: rtl/aes_sub_word.sv
// AES SubWord: forward S-box substitution applied to each byte of a 32-bit word.
module aes_sub_word
    import aes_pkg::*;
(
    input  logic [31:0] word_i,
    output logic [31:0] word_o
);

    assign word_o = {SBOX[word_i[31:24]], SBOX[word_i[23:16]],
                     SBOX[word_i[15:8]],  SBOX[word_i[7:0]]};

endmodule

// File: rtl/aes_key_schedule.sv
// Iterative AES-128 key expansion: loads a cipher key and hands out round keys 0..10
// over a valid/ready handshake, computing one new round key per accepted transfer.
module aes_key_schedule
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         START,
    input  logic [127:0] KEY_IN,
    output logic         READY,
    output logic         RK_VALID,
    input  logic         RK_READY,
    output logic [3:0]   RK_ROUND,
    output logic [127:0] RK
);

    localparam logic [3:0] LastRound = 4'(NUM_ROUNDS);

    ks_state_e    state_q, state_d;
    logic [127:0] rk_q, rk_d;
    logic [3:0]   round_q, round_d;

    logic [3:0]   round_inc;
    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  rot_w3, sub_w3, t_word;
    logic [127:0] next_key;

    assign round_inc = round_q + 4'd1;
    assign {w0, w1, w2, w3} = rk_q;
    assign rot_w3 = {w3[23:0], w3[31:24]};

    aes_sub_word u_sub_word (
        .word_i (rot_w3),
        .word_o (sub_w3)
    );

    assign t_word = sub_w3 ^ {RCON[round_inc], 24'h0};

    always_comb begin
        logic [31:0] n0, n1, n2, n3;
        n0 = w0 ^ t_word;
        n1 = w1 ^ n0;
        n2 = w2 ^ n1;
        n3 = w3 ^ n2;
        next_key = {n0, n1, n2, n3};
    end

    always_comb begin
        state_d = state_q;
        rk_d    = rk_q;
        round_d = round_q;
        case (state_q)
            IDLE: begin
                if (START) begin
                    state_d = BUSY;
                    rk_d    = KEY_IN;
                    round_d = 4'd0;
                end
            end
            BUSY: begin
                if (RK_READY) begin
                    if (round_q == LastRound) begin
                        state_d = IDLE;
                    end else begin
                        rk_d    = next_key;
                        round_d = round_inc;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rk_q    <= '0;
            round_q <= '0;
        end else begin
            state_q <= state_d;
            rk_q    <= rk_d;
            round_q <= round_d;
        end
    end

    assign READY    = (state_q == IDLE);
    assign RK_VALID = (state_q == BUSY);
    assign RK_ROUND = round_q;
    assign RK       = rk_q;

endmodule

// File: tb/tb_aes_key_schedule.sv
// Self-checking bench for aes_key_schedule: FIPS-197 vectors, random keys against a
// GF(2^8)-arithmetic key-expansion model, backpressure, START while busy, reset, back-to-back.
module tb_aes_key_schedule;

    logic         clk;
    logic         rst_n;
    logic         START;
    logic [127:0] KEY_IN;
    logic         READY;
    logic         RK_VALID;
    logic         RK_READY;
    logic [3:0]   RK_ROUND;
    logic [127:0] RK;

    aes_key_schedule dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .START    (START),
        .KEY_IN   (KEY_IN),
        .READY    (READY),
        .RK_VALID (RK_VALID),
        .RK_READY (RK_READY),
        .RK_ROUND (RK_ROUND),
        .RK       (RK)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;

    logic [127:0] exp_rk [11];
    logic [127:0] got    [11];

    typedef struct {
        logic [127:0] key;
        int unsigned  round;
        logic [127:0] rk;
    } vec_t;

    vec_t vecs [6];

    localparam logic [127:0] KeyA1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Reference model built from field arithmetic rather than a lookup table.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] ref_sbox(input logic [7:0] a);
        logic [7:0] inv = 8'h00;
        if (a != 8'h00) begin
            inv = 8'h01;
            for (int i = 0; i < 254; i++) inv = gmul(inv, a);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    task automatic model_expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] temp;
        logic [7:0]  rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            temp = w[i-1];
            if (i % 4 == 0) begin
                temp = {temp[23:0], temp[31:24]};
                temp = {ref_sbox(temp[31:24]), ref_sbox(temp[23:16]),
                        ref_sbox(temp[15:8]), ref_sbox(temp[7:0])} ^ {rcon, 24'h0};
                rcon = gmul(rcon, 8'h02);
            end
            w[i] = w[i-4] ^ temp;
        end
        for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic start_key(input logic [127:0] key);
        int k = 0;
        while (!READY && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("ready_before_start", 128'(READY), 128'd1);
        START  = 1'b1;
        KEY_IN = key;
        @(negedge clk);
        START  = 1'b0;
        check("load_latency_valid", 128'(RK_VALID), 128'd1);
    endtask

    // Entered at the first cycle round 0 is presented; checks every accepted key against
    // exp_rk and holds during stalls. busy_at >= 0 pulses START with all-ones at that round.
    task automatic collect(input bit bp, input int busy_at);
        int unsigned  n = 0;
        int unsigned  cyc = 0;
        bit           prev_stall = 1'b0;
        logic [127:0] prev_rk = '0;
        logic [3:0]   prev_round = '0;
        bit           rdy;
        while (n < 11 && cyc < 300) begin
            if (prev_stall) begin
                check("stall_hold_rk", RK, prev_rk);
                check("stall_hold_round", 128'(RK_ROUND), 128'(prev_round));
            end
            check("valid_while_busy", 128'(RK_VALID), 128'd1);
            if (busy_at >= 0 && int'(n) == busy_at && !prev_stall) begin
                START  = 1'b1;
                KEY_IN = '1;
            end else begin
                START  = 1'b0;
            end
            rdy      = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            RK_READY = rdy;
            if (rdy) begin
                check("round_index", 128'(RK_ROUND), 128'(n));
                check("round_key", RK, exp_rk[n]);
                got[n] = RK;
                n++;
            end
            prev_stall = !rdy;
            prev_rk    = RK;
            prev_round = RK_ROUND;
            @(negedge clk);
            cyc++;
        end
        START    = 1'b0;
        RK_READY = 1'b0;
        if (n < 11) begin
            n_cmp++;
            n_fail++;
            $display("FAIL collect_timeout: got %0d keys, required 11", n);
        end
        if (!bp) check("steady_state_cycles", 128'(cyc), 128'd11);
        check("ready_after_final", 128'(READY), 128'd1);
        check("valid_after_final", 128'(RK_VALID), 128'd0);
    endtask

    initial begin
        logic [127:0] k2;
        int           k;

        vecs[0] = '{key: KeyA1, round: 1, rk: 128'ha0fafe1788542cb123a339392a6c7605};
        vecs[1] = '{key: KeyA1, round: 2, rk: 128'hf2c295f27a96b9435935807a7359f67f};
        vecs[2] = '{key: KeyA1, round: 10, rk: 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        vecs[3] = '{key: 128'h0, round: 1, rk: 128'h62636363626363636263636362636363};
        vecs[4] = '{key: 128'h0, round: 2, rk: 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa};
        vecs[5] = '{key: 128'h0, round: 10, rk: 128'hb4ef5bcb3e92e21123e951cf6f8f188e};

        rst_n    = 1'b0;
        START    = 1'b0;
        KEY_IN   = '0;
        RK_READY = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_ready", 128'(READY), 128'd1);
        check("reset_valid", 128'(RK_VALID), 128'd0);
        check("reset_rk", RK, 128'd0);
        check("reset_round", 128'(RK_ROUND), 128'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Known-answer vectors, no backpressure.
        for (int i = 0; i < 6; i++) begin
            model_expand(vecs[i].key);
            start_key(vecs[i].key);
            check("round0_is_key", RK, vecs[i].key);
            collect(1'b0, -1);
            check($sformatf("vec%0d_round%0d", i, vecs[i].round), got[vecs[i].round], vecs[i].rk);
        end

        // Backpressure on the FIPS key.
        model_expand(KeyA1);
        start_key(KeyA1);
        collect(1'b1, -1);
        check("bp_round10", got[10], vecs[2].rk);

        // Random keys with backpressure against the model.
        for (int i = 0; i < 4; i++) begin
            k2 = {$urandom, $urandom, $urandom, $urandom};
            model_expand(k2);
            start_key(k2);
            collect(1'b1, -1);
        end

        // START while busy must not disturb the sequence.
        model_expand(KeyA1);
        start_key(KeyA1);
        collect(1'b0, 4);
        check("busy_start_round10", got[10], vecs[2].rk);

        // Asynchronous reset in the middle of a run.
        start_key(KeyA1);
        RK_READY = 1'b1;
        k = 0;
        while (RK_ROUND != 4'd6 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("reached_round6", 128'(RK_ROUND), 128'd6);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_ready", 128'(READY), 128'd1);
        check("midreset_valid", 128'(RK_VALID), 128'd0);
        check("midreset_rk", RK, 128'd0);
        check("midreset_round", 128'(RK_ROUND), 128'd0);
        @(negedge clk);
        RK_READY = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
        model_expand(128'h0);
        start_key(128'h0);
        collect(1'b0, -1);
        check("after_reset_round1", got[1], vecs[3].rk);

        // Back-to-back: START held from t+11, accepted at t+12, round 0 at t+13.
        k2 = {$urandom, $urandom, $urandom, $urandom};
        start_key(KeyA1);
        RK_READY = 1'b1;
        repeat (10) @(negedge clk);
        check("b2b_round10_at_t11", 128'(RK_ROUND), 128'd10);
        START  = 1'b1;
        KEY_IN = k2;
        @(negedge clk);
        check("b2b_ready_t12", 128'(READY), 128'd1);
        check("b2b_valid_t12", 128'(RK_VALID), 128'd0);
        @(negedge clk);
        START = 1'b0;
        check("b2b_valid_t13", 128'(RK_VALID), 128'd1);
        check("b2b_round_t13", 128'(RK_ROUND), 128'd0);
        check("b2b_key_t13", RK, k2);
        model_expand(k2);
        collect(1'b0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
